// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
//   Registered decode-stage instruction decoder for 32-bit MIPS-style words.
//   Slices the instruction into its raw fields, classifies the format
//   (R/I/J), builds the extended immediate and the jump target field, and
//   flags unsupported opcode/funct combinations. All outputs come from
//   registers and appear one cycle after a valid instruction is presented.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset (all outputs forced to 0)
//   instr        instruction word to decode
//   instr_valid  instr is valid this cycle
//   opcode       instr[31:26]
//   rs1          instr[25:21]
//   rs2          instr[20:16]
//   rd           instr[15:11]
//   shmt         instr[10:6]
//   funct        instr[5:0]
//   imm_ext      zero/sign/upper-extended instr[15:0] (depends on opcode)
//   jaddr        instr[25:0]
//   is_rtype     opcode == 0x00
//   is_jtype     opcode == 0x02 or 0x03
//   is_itype     any other opcode
//   illegal      unsupported opcode, or R-type with unsupported funct
//   out_valid    registered instr_valid
// -----------------------------------------------------------------------------
module instr_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [4:0]  shmt,
  output logic [5:0]  funct,
  output logic [31:0] imm_ext,
  output logic [25:0] jaddr,
  output logic        is_rtype,
  output logic        is_jtype,
  output logic        is_itype,
  output logic        illegal,
  output logic        out_valid
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  shmt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [25:0] jaddr;
    logic        is_rtype;
    logic        is_jtype;
    logic        is_itype;
    logic        illegal;
  } dec_t;

  dec_t w_dec;
  dec_t r_dec;
  logic r_out_valid;
  logic w_op_ok;
  logic w_fn_ok;

  // Combinational decode of the incoming word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can leave it unassigned (no latches).
    w_dec   = '0;
    w_op_ok = 1'b0;
    w_fn_ok = 1'b0;

    // Raw, format-independent field slicing.
    w_dec.opcode = instr[31:26];
    w_dec.rs1    = instr[25:21];
    w_dec.rs2    = instr[20:16];
    w_dec.rd     = instr[15:11];
    w_dec.shmt   = instr[10:6];
    w_dec.funct  = instr[5:0];
    w_dec.jaddr  = instr[25:0];

    // Logical immediates are zero-extended, lui places the half-word in the
    // upper 16 bits; everything else (R and J included) is sign-extended.
    case (instr[31:26])
      OP_ANDI, OP_ORI: w_dec.imm_ext = {16'h0000, instr[15:0]};
      OP_LUI:          w_dec.imm_ext = {instr[15:0], 16'h0000};
      default:         w_dec.imm_ext = {{16{instr[15]}}, instr[15:0]};
    endcase

    // Format classification: exactly one flag is set for any opcode.
    w_dec.is_rtype = (instr[31:26] == OP_RTYPE);
    w_dec.is_jtype = (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    w_dec.is_itype = !w_dec.is_rtype && !w_dec.is_jtype;

    case (instr[31:26])
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: w_op_ok = 1'b1;
      default:                                        w_op_ok = 1'b0;
    endcase

    case (instr[5:0])
      FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:
        w_fn_ok = 1'b1;
      default:
        w_fn_ok = 1'b0;
    endcase

    // funct only matters for R-type words.
    w_dec.illegal = !w_op_ok || (w_dec.is_rtype && !w_fn_ok);
  end

  // Output register: fields load only on a valid word and otherwise hold;
  // out_valid simply follows instr_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_dec       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= instr_valid;
      if (instr_valid) begin
        r_dec <= w_dec;
      end
    end
  end

  assign opcode    = r_dec.opcode;
  assign rs1       = r_dec.rs1;
  assign rs2       = r_dec.rs2;
  assign rd        = r_dec.rd;
  assign shmt      = r_dec.shmt;
  assign funct     = r_dec.funct;
  assign imm_ext   = r_dec.imm_ext;
  assign jaddr     = r_dec.jaddr;
  assign is_rtype  = r_dec.is_rtype;
  assign is_jtype  = r_dec.is_jtype;
  assign is_itype  = r_dec.is_itype;
  assign illegal   = r_dec.illegal;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_instr_decoder.sv
// -----------------------------------------------------------------------------
// tb_instr_decoder
//   Directed-vector bench for instr_decoder. Expected values are hand
//   computed from the instruction encodings.
// -----------------------------------------------------------------------------
module tb_instr_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [4:0]  shmt;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;
  logic        is_rtype;
  logic        is_jtype;
  logic        is_itype;
  logic        illegal;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  instr_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .shmt        (shmt),
    .funct       (funct),
    .imm_ext     (imm_ext),
    .jaddr       (jaddr),
    .is_rtype    (is_rtype),
    .is_jtype    (is_jtype),
    .is_itype    (is_itype),
    .illegal     (illegal),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a word at the falling edge, let the rising edge capture it, and
  // sample shortly after that edge.
  task automatic step(input logic [31:0] word, input logic vld);
    @(negedge clk);
    instr       = word;
    instr_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic check_fmt(input string tag, input logic r, input logic i,
                           input logic j, input logic ill);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".is_rtype"},  32'(is_rtype),  32'(r));
    check({tag, ".is_itype"},  32'(is_itype),  32'(i));
    check({tag, ".is_jtype"},  32'(is_jtype),  32'(j));
    check({tag, ".illegal"},   32'(illegal),   32'(ill));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".opcode"},    32'(opcode),    32'd0);
    check({tag, ".rs1"},       32'(rs1),       32'd0);
    check({tag, ".rs2"},       32'(rs2),       32'd0);
    check({tag, ".rd"},        32'(rd),        32'd0);
    check({tag, ".shmt"},      32'(shmt),      32'd0);
    check({tag, ".funct"},     32'(funct),     32'd0);
    check({tag, ".imm_ext"},   imm_ext,        32'd0);
    check({tag, ".jaddr"},     32'(jaddr),     32'd0);
    check({tag, ".is_rtype"},  32'(is_rtype),  32'd0);
    check({tag, ".is_itype"},  32'(is_itype),  32'd0);
    check({tag, ".is_jtype"},  32'(is_jtype),  32'd0);
    check({tag, ".illegal"},   32'(illegal),   32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    instr       = 32'h0;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    @(negedge clk);
    rst = 1'b0;

    // All-zero word: legal sll no-op.
    step(32'h0000_0000, 1'b1);
    check("nop.opcode",  32'(opcode),  32'h00);
    check("nop.rd",      32'(rd),      32'd0);
    check("nop.funct",   32'(funct),   32'h00);
    check("nop.imm_ext", imm_ext,      32'h0);
    check_fmt("nop", 1'b1, 1'b0, 1'b0, 1'b0);

    // add $t1,$t2,$t3
    step(32'h014B_4820, 1'b1);
    check("add.opcode",  32'(opcode),  32'h00);
    check("add.rs1",     32'(rs1),     32'd10);
    check("add.rs2",     32'(rs2),     32'd11);
    check("add.rd",      32'(rd),      32'd9);
    check("add.shmt",    32'(shmt),    32'd0);
    check("add.funct",   32'(funct),   32'h20);
    check("add.imm_ext", imm_ext,      32'h0000_4820);
    check("add.jaddr",   32'(jaddr),   32'h014_B4820);
    check_fmt("add", 1'b1, 1'b0, 1'b0, 1'b0);

    // addi $t1,$t1,-1 : raw fields still driven for I-type
    step(32'h2129_FFFF, 1'b1);
    check("addi.opcode",  32'(opcode), 32'h08);
    check("addi.rs1",     32'(rs1),    32'd9);
    check("addi.rs2",     32'(rs2),    32'd9);
    check("addi.rd",      32'(rd),     32'd31);
    check("addi.shmt",    32'(shmt),   32'd31);
    check("addi.funct",   32'(funct),  32'h3F);
    check("addi.imm_ext", imm_ext,     32'hFFFF_FFFF);
    check_fmt("addi", 1'b0, 1'b1, 1'b0, 1'b0);

    // ori: zero extension
    step(32'h3529_FFFF, 1'b1);
    check("ori.opcode",  32'(opcode), 32'h0D);
    check("ori.imm_ext", imm_ext,     32'h0000_FFFF);
    check_fmt("ori", 1'b0, 1'b1, 1'b0, 1'b0);

    // lui: upper placement
    step(32'h3C09_1234, 1'b1);
    check("lui.opcode",  32'(opcode), 32'h0F);
    check("lui.rs2",     32'(rs2),    32'd9);
    check("lui.imm_ext", imm_ext,     32'h1234_0000);
    check_fmt("lui", 1'b0, 1'b1, 1'b0, 1'b0);

    // andi with bit 15 set: zero extension, not sign extension
    step(32'h3129_8000, 1'b1);
    check("andi.opcode",  32'(opcode), 32'h0C);
    check("andi.imm_ext", imm_ext,     32'h0000_8000);
    check_fmt("andi", 1'b0, 1'b1, 1'b0, 1'b0);

    // addi with 0x8000: most negative immediate
    step(32'h2129_8000, 1'b1);
    check("addi8k.imm_ext", imm_ext, 32'hFFFF_8000);

    // jal
    step(32'h0C10_0004, 1'b1);
    check("jal.opcode",  32'(opcode), 32'h03);
    check("jal.jaddr",   32'(jaddr),  32'h010_0004);
    check("jal.imm_ext", imm_ext,     32'h0000_0004);
    check_fmt("jal", 1'b0, 1'b0, 1'b1, 1'b0);

    // j with max target; imm sign-extended even for J-type
    step(32'h0BFF_FFFF, 1'b1);
    check("j.opcode",  32'(opcode), 32'h02);
    check("j.jaddr",   32'(jaddr),  32'h3FF_FFFF);
    check("j.imm_ext", imm_ext,     32'hFFFF_FFFF);
    check_fmt("j", 1'b0, 1'b0, 1'b1, 1'b0);

    // Unsupported opcode 0x3F
    step(32'hFC00_0000, 1'b1);
    check("op3f.opcode", 32'(opcode), 32'h3F);
    check_fmt("op3f", 1'b0, 1'b1, 1'b0, 1'b1);

    // R-type with unsupported funct 0x21
    step(32'h0000_0021, 1'b1);
    check("fn21.funct", 32'(funct), 32'h21);
    check_fmt("fn21", 1'b1, 1'b0, 1'b0, 1'b1);

    // I-type whose low bits look like a bad funct is still legal (lw)
    step(32'h8D09_0021, 1'b1);
    check("lw.opcode", 32'(opcode), 32'h23);
    check_fmt("lw", 1'b0, 1'b1, 1'b0, 1'b0);

    // jr $ra
    step(32'h03E0_0008, 1'b1);
    check("jr.rs1",   32'(rs1),   32'd31);
    check("jr.funct", 32'(funct), 32'h08);
    check_fmt("jr", 1'b1, 1'b0, 1'b0, 1'b0);

    // Hold: valid drops, instr changes, fields keep the add decode
    step(32'h014B_4820, 1'b1);
    check("hold_ld.rd", 32'(rd), 32'd9);
    step(32'h2129_FFFF, 1'b0);
    check("hold.out_valid", 32'(out_valid), 32'd0);
    check("hold.rd",        32'(rd),        32'd9);
    check("hold.opcode",    32'(opcode),    32'h00);
    check("hold.funct",     32'(funct),     32'h20);
    check("hold.imm_ext",   imm_ext,        32'h0000_4820);
    check("hold.is_rtype",  32'(is_rtype),  32'd1);
    step(32'h3529_FFFF, 1'b0);
    check("hold2.rs1",      32'(rs1),       32'd10);

    // Back-to-back valid words, each one cycle later
    step(32'h3C09_1234, 1'b1);
    check("b2b0.out_valid", 32'(out_valid), 32'd1);
    check("b2b0.imm_ext",   imm_ext,        32'h1234_0000);
    step(32'h0C10_0004, 1'b1);
    check("b2b1.out_valid", 32'(out_valid), 32'd1);
    check("b2b1.opcode",    32'(opcode),    32'h03);
    step(32'hFC00_0000, 1'b1);
    check("b2b2.opcode",    32'(opcode),    32'h3F);
    check("b2b2.illegal",   32'(illegal),   32'd1);

    // Asynchronous reset mid-cycle with nonzero outputs, no clock edge
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");

    // Held across an edge with a valid word presented: stays zero
    @(negedge clk);
    instr       = 32'h2129_FFFF;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");

    // Release at the falling edge: the next rising edge samples normally
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.opcode",  32'(opcode), 32'h08);
    check("post_rst.imm_ext", imm_ext,     32'hFFFF_FFFF);
    check_fmt("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
